// File: rtl/btn_pkg.sv
// Shared definitions for the button event writer: write FSM states, event word
// layout and the default target address.
package btn_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_FF00;

  localparam int OVF_BIT    = 31;
  localparam int SEQ_LSB    = 24;
  localparam int SEQ_W      = 7;
  localparam int MASK_W_MAX = 24;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  // Bits between the mask and the sequence field stay zero because the mask
  // arrives zero-extended to the full 24-bit field.
  function automatic logic [31:0] pack_event(input logic                  ovf,
                                             input logic [SEQ_W-1:0]      seq,
                                             input logic [MASK_W_MAX-1:0] mask);
    logic [31:0] w;
    w = '0;
    w[OVF_BIT]                = ovf;
    w[SEQ_LSB +: SEQ_W]       = seq;
    w[MASK_W_MAX-1:0]         = mask;
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, debounced state
// and a pulse that is high on the edge where the state goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic state,
  output logic rise
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          state_reg;
  logic [CW-1:0] cnt_reg;
  logic          flip;

  // The flip is decided combinationally so the rise pulse coincides with the
  // edge that updates the debounced state.
  assign flip  = (sync2_reg != state_reg) && (cnt_reg == CNT_LAST);
  assign rise  = flip && sync2_reg;
  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      state_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      if (sync2_reg == state_reg) begin
        cnt_reg <= '0;
      end else if (flip) begin
        cnt_reg   <= '0;
        state_reg <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_event_writer.sv
// Debounces NUM_BTN buttons, queues press masks as sequenced event words and
// writes each word to a fixed memory-mapped address through a req/ack handshake.
module btn_event_writer
  import btn_pkg::*;
#(
  parameter int          NUM_BTN         = 5,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               wack,
  output logic               we,
  output logic [31:0]        waddr,
  output logic [31:0]        wdata,
  output logic [3:0]         select,
  output logic               enabler
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [NUM_BTN-1:0]    deb_state;
  logic [NUM_BTN-1:0]    deb_rise;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn[gi]),
        .state(deb_state[gi]),
        .rise (deb_rise[gi])
      );
    end
  endgenerate

  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [SEQ_W-1:0]      seq_reg;
  logic                  drop_reg;
  logic                  enabler_reg;
  logic                  we_reg;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic [MASK_W_MAX-1:0] mask_ext;
  wr_state_t             state_reg;
  wr_state_t             state_next;

  assign mask_ext   = MASK_W_MAX'(deb_rise);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push_req   = |deb_rise;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= pack_event(drop_reg, seq_reg, mask_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      seq_reg    <= '0;
      drop_reg   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        seq_reg    <= seq_reg + 1'b1;
        drop_reg   <= 1'b0;
      end else if (push_req) begin
        drop_reg   <= 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Leaving WRITE always passes through IDLE, which guarantees the gap
  // between consecutive writes.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wack) begin
          pop        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      we_reg      <= 1'b0;
      enabler_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      we_reg      <= (state_next == ST_WRITE);
      enabler_reg <= |deb_state;
    end
  end

  // The head only moves on pop, so these stay stable for the whole write.
  assign we      = we_reg;
  assign waddr   = we_reg ? BASE_ADDR : 32'h0;
  assign select  = we_reg ? 4'b1111 : 4'b0000;
  assign wdata   = we_reg ? fifo_mem[rd_ptr_reg] : 32'h0;
  assign enabler = enabler_reg;

endmodule

// File: tb/tb_btn_event_writer.sv
// Scoreboard bench for btn_event_writer: expected event words are queued when a
// press is driven and compared when the DUT starts the matching write.
module tb_btn_event_writer;

  localparam int          NB   = 5;
  localparam logic [31:0] BASE = 32'h0000_FF00;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn;
  logic          wack;
  logic          we;
  logic [31:0]   waddr;
  logic [31:0]   wdata;
  logic [3:0]    select;
  logic          enabler;

  btn_event_writer #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .wack   (wack),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .select (select),
    .enabler(enabler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec    = 0;
  int          n_err    = 0;
  int          n_writes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held_word = '0;
  logic        smp_rst  = 1'b0;
  logic        smp_we   = 1'b0;
  logic        smp_wack = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs and the pre-edge value of we as seen by the DUT at each edge.
  always @(posedge clk) begin
    smp_rst  <= rst;
    smp_we   <= we;
    smp_wack <= wack;
  end

  always @(negedge clk) begin
    check_eq("waddr_map", waddr, we ? BASE : 32'h0);
    check_eq("select_map", {28'h0, select}, we ? 32'hF : 32'h0);
    if (!we) check_eq("wdata_idle", wdata, 32'h0);
    if (smp_rst) begin
      check_eq("rst_we", 32'(we), 32'h0);
      check_eq("rst_enabler", 32'(enabler), 32'h0);
    end else if (smp_we && smp_wack) begin
      check_eq("gap_after_ack", 32'(we), 32'h0);
    end else if (smp_we && we) begin
      check_eq("wdata_stable", wdata, held_word);
    end
    if (we && !smp_we) begin
      n_writes++;
      held_word = wdata;
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'h1);
      end else begin
        $display("write %0d: wdata=%h waddr=%h select=%h", n_writes, wdata, waddr, select);
        check_eq("wdata", wdata, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [NB-1:0] m, input int hold);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_we(input int max_cyc);
    for (int i = 0; i < max_cyc && !we; i++) @(negedge clk);
    check_eq("we_timeout", 32'(we), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    btn  = '0;
    wack = 1'b1;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_we", 32'(we), 32'h0);
    check_eq("reset_waddr", waddr, 32'h0);
    check_eq("reset_wdata", wdata, 32'h0);
    check_eq("reset_select", 32'(select), 32'h0);
    check_eq("reset_enabler", 32'(enabler), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single press: we must rise exactly after edge k+6 (first sampled at k).
    exp_q.push_back(32'h0000_0001);
    btn = 5'b00001;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      check_eq($sformatf("latency_we_%0d", j), 32'(we), (j == 7) ? 32'h1 : 32'h0);
      check_eq($sformatf("latency_enabler_%0d", j), 32'(enabler), (j >= 7) ? 32'h1 : 32'h0);
    end
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);

    // Three-cycle glitch is shorter than the debounce window.
    w0 = n_writes;
    btn = 5'b00001;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (15) @(negedge clk);
    check_eq("glitch_no_write", 32'(n_writes), 32'(w0));
    check_eq("glitch_enabler", 32'(enabler), 32'h0);

    // Simultaneous presses share one entry, seq 0 after reset.
    do_reset();
    exp_q.push_back(32'h0000_0012);
    press(5'b10010, 10);

    // Stalled writer: four entries fit, the fifth overflows.
    do_reset();
    wack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back((32'(i) << 24) | (32'h1 << i));
      press(NB'(1 << i), 8);
    end
    check_eq("stall_we_held", 32'(we), 32'h1);
    check_eq("stall_pending", 32'(exp_q.size()), 32'h3);
    wack = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("drain_pending", 32'(exp_q.size()), 32'h0);
    exp_q.push_back(32'h8400_0001);
    press(5'b00001, 8);

    // Ack delayed three cycles.
    wack = 1'b0;
    exp_q.push_back(32'h0500_0004);
    btn = 5'b00100;
    wait_we(40);
    repeat (3) @(negedge clk);
    check_eq("delayed_we_held", 32'(we), 32'h1);
    wack = 1'b1;
    @(negedge clk);
    wack = 1'b0;
    check_eq("delayed_we_drop", 32'(we), 32'h0);
    btn = '0;
    repeat (12) @(negedge clk);

    // Reset mid-write with the button still held.
    exp_q.push_back(32'h0600_0002);
    btn = 5'b00010;
    wait_we(40);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_we", 32'(we), 32'h0);
    check_eq("midrst_enabler", 32'(enabler), 32'h0);
    exp_q.push_back(32'h0000_0002);
    wack = 1'b1;
    repeat (20) @(negedge clk);
    btn = '0;
    repeat (15) @(negedge clk);

    check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
    check_eq("write_count", 32'(n_writes), 32'd10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
